// File: rtl/pe_feeder.sv
// Operand feeder for a systolic PE: host-loaded A/B pair buffer streamed out as
// a start pulse followed by alternating A/B write strobes, throttled by aff/bff.
module pe_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_we,
    input  logic [AW-1:0]        ld_addr,
    input  logic signed [15:0]   ld_a,
    input  logic signed [15:0]   ld_b,
    input  logic                 go,
    input  logic [7:0]           len,
    input  logic                 aff,
    input  logic                 bff,
    output logic                 start,
    output logic                 awe,
    output logic                 bwe,
    output logic signed [15:0]   a_out,
    output logic signed [15:0]   b_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED_A,
        S_FEED_B,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [AW:0]        idx_q, idx_d;
    logic [AW:0]        n_q, n_d;
    logic signed [15:0] a_out_q, a_out_d;
    logic signed [15:0] b_out_q, b_out_d;
    logic [AW:0]        len_clamped;

    // Operand storage is deliberately left out of reset.
    logic signed [15:0] buf_a [DEPTH];
    logic signed [15:0] buf_b [DEPTH];

    always_ff @(posedge clk) begin
        if (ld_we && !busy) begin
            buf_a[ld_addr] <= ld_a;
            buf_b[ld_addr] <= ld_b;
        end
    end

    always_comb begin
        len_clamped = (int'(len) >= DEPTH) ? (AW+1)'(DEPTH) : (AW+1)'(len);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        a_out_d = a_out_q;
        b_out_d = b_out_q;
        start   = 1'b0;
        awe     = 1'b0;
        bwe     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    n_d     = len_clamped;
                    idx_d   = '0;
                    state_d = (len_clamped == '0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                start   = 1'b1;
                busy    = 1'b1;
                a_out_d = buf_a[idx_q[AW-1:0]];
                state_d = S_FEED_A;
            end
            S_FEED_A: begin
                busy = 1'b1;
                awe  = ~aff;
                if (!aff) begin
                    b_out_d = buf_b[idx_q[AW-1:0]];
                    state_d = S_FEED_B;
                end
            end
            S_FEED_B: begin
                busy = 1'b1;
                bwe  = ~bff;
                if (!bff) begin
                    if (idx_q == n_q - (AW+1)'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        // Preload the next A so it is valid on FEED_A entry.
                        idx_d   = idx_q + (AW+1)'(1);
                        a_out_d = buf_a[idx_d[AW-1:0]];
                        state_d = S_FEED_A;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
        end
    end

    assign a_out = a_out_q;
    assign b_out = b_out_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: each run is captured cycle by cycle, then each
// scenario task compares the capture against hand-computed expectations.
module tb_pe_feeder;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NREC  = 64;

    logic clk = 1'b0;
    logic rst, ld_we, go, aff, bff;
    logic [AW-1:0] ld_addr;
    logic signed [15:0] ld_a, ld_b;
    logic [7:0] len;
    logic start, awe, bwe, busy, done;
    logic signed [15:0] a_out, b_out;

    pe_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_a(ld_a), .ld_b(ld_b),
        .go(go), .len(len), .aff(aff), .bff(bff), .start(start), .awe(awe), .bwe(bwe),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic r_start [NREC];
    logic r_awe   [NREC];
    logic r_bwe   [NREC];
    logic r_busy  [NREC];
    logic r_done  [NREC];
    logic signed [15:0] r_a [NREC];
    logic signed [15:0] r_b [NREC];
    logic s_aff [NREC];
    logic s_bff [NREC];
    logic s_inj [NREC];
    logic s_rst [NREC];

    task automatic clear_sched();
        for (int i = 0; i < NREC; i++) begin
            s_aff[i] = 1'b0; s_bff[i] = 1'b0; s_inj[i] = 1'b0; s_rst[i] = 1'b0;
        end
    endtask

    task automatic load(input int addr, input int a, input int b);
        ld_we = 1'b1; ld_addr = AW'(addr); ld_a = 16'(a); ld_b = 16'(b);
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    task automatic load_orig();
        load(0, 100, 200); load(1, 200, 130); load(2, 255, 256); load(3, 100, 300); load(4, 0, 0);
    endtask

    // Issue go (edge T), then record cycles T+1 .. T+ncyc applying the schedules.
    task automatic run(input logic [7:0] l, input int ncyc);
        len = l; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            aff = s_aff[c]; bff = s_bff[c]; rst = s_rst[c];
            if (s_inj[c]) begin
                ld_we = 1'b1; ld_addr = '0; ld_a = -16'sd5; ld_b = -16'sd7; go = 1'b1; len = 8'd2;
            end else begin
                ld_we = 1'b0; go = 1'b0;
            end
            #1;
            r_start[c] = start; r_awe[c] = awe; r_bwe[c] = bwe; r_busy[c] = busy;
            r_done[c] = done; r_a[c] = a_out; r_b[c] = b_out;
            @(posedge clk); #1;
        end
        aff = 1'b0; bff = 1'b0; rst = 1'b0; ld_we = 1'b0; go = 1'b0;
        $display("run len=%0d cycles=%0d", l, ncyc);
    endtask

    function automatic int count_sig(input int sel, input int n);
        int k = 0;
        for (int c = 1; c <= n; c++) begin
            case (sel)
                0: k += int'(r_start[c]);
                1: k += int'(r_awe[c]);
                2: k += int'(r_bwe[c]);
                3: k += int'(r_busy[c]);
                default: k += int'(r_done[c]);
            endcase
        end
        return k;
    endfunction

    function automatic int first_done(input int n);
        for (int c = 1; c <= n; c++) if (r_done[c]) return c;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; ld_we = 1'b0; go = 1'b0; len = '0; aff = 1'b0; bff = 1'b0;
        ld_addr = '0; ld_a = '0; ld_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({start, awe, bwe, busy, done} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=00000", {start, awe, bwe, busy, done});
        end
        checks++;
        if (a_out !== 16'sd0 || b_out !== 16'sd0) begin
            failures++; $display("FAIL reset_data got a=%0d b=%0d want 0/0", a_out, b_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int ea[5] = '{100, 200, 255, 100, 0};
        int eb[5] = '{200, 130, 256, 300, 0};
        int ka = 0, kb = 0;
        load_orig();
        clear_sched();
        run(8'd5, 14);
        checks++;
        if (r_start[1] !== 1'b1 || count_sig(0, 14) !== 1) begin
            failures++; $display("FAIL basic_start got s1=%b cnt=%0d want 1/1", r_start[1], count_sig(0, 14));
        end
        for (int c = 1; c <= 14; c++) begin
            if (r_awe[c] && r_bwe[c]) begin
                checks++; failures++; $display("FAIL basic_overlap cycle=%0d got both strobes want one", c);
            end
            if (r_awe[c] && ka < 5) begin
                checks++;
                if (c !== 2 + 2 * ka || r_a[c] !== 16'(ea[ka])) begin
                    failures++; $display("FAIL basic_a%0d got cyc=%0d a=%0d want cyc=%0d a=%0d", ka, c, r_a[c], 2 + 2 * ka, ea[ka]);
                end
                ka++;
            end
            if (r_bwe[c] && kb < 5) begin
                checks++;
                if (c !== 3 + 2 * kb || r_b[c] !== 16'(eb[kb])) begin
                    failures++; $display("FAIL basic_b%0d got cyc=%0d b=%0d want cyc=%0d b=%0d", kb, c, r_b[c], 3 + 2 * kb, eb[kb]);
                end
                kb++;
            end
        end
        checks++;
        if (count_sig(1, 14) !== 5 || count_sig(2, 14) !== 5) begin
            failures++; $display("FAIL basic_counts got awe=%0d bwe=%0d want 5/5", count_sig(1, 14), count_sig(2, 14));
        end
        checks++;
        if (first_done(14) !== 12 || count_sig(4, 14) !== 1) begin
            failures++; $display("FAIL basic_done got cyc=%0d cnt=%0d want 12/1", first_done(14), count_sig(4, 14));
        end
        checks++;
        if (r_busy[1] !== 1'b1 || r_busy[11] !== 1'b1 || r_busy[12] !== 1'b0) begin
            failures++; $display("FAIL basic_busy got %b%b%b want 110", r_busy[1], r_busy[11], r_busy[12]);
        end
    endtask

    task automatic test_aff_stall();
        int ea[5] = '{100, 200, 255, 100, 0};
        int ec[5] = '{2, 7, 9, 11, 13};
        int ka = 0;
        clear_sched();
        s_aff[4] = 1'b1; s_aff[5] = 1'b1; s_aff[6] = 1'b1;
        run(8'd5, 17);
        for (int c = 4; c <= 6; c++) begin
            checks++;
            if (r_awe[c] !== 1'b0 || r_a[c] !== 16'sd200) begin
                failures++; $display("FAIL aff_hold cycle=%0d got awe=%b a=%0d want 0/200", c, r_awe[c], r_a[c]);
            end
        end
        for (int c = 1; c <= 17; c++) begin
            if (r_awe[c] && ka < 5) begin
                checks++;
                if (c !== ec[ka] || r_a[c] !== 16'(ea[ka])) begin
                    failures++; $display("FAIL aff_a%0d got cyc=%0d a=%0d want cyc=%0d a=%0d", ka, c, r_a[c], ec[ka], ea[ka]);
                end
                ka++;
            end
        end
        checks++;
        if (count_sig(1, 17) !== 5 || count_sig(2, 17) !== 5 || first_done(17) !== 15) begin
            failures++; $display("FAIL aff_summary got awe=%0d bwe=%0d done=%0d want 5/5/15", count_sig(1, 17), count_sig(2, 17), first_done(17));
        end
    endtask

    task automatic test_bff_last();
        int ec[5] = '{3, 5, 7, 9, 14};
        int kb = 0;
        clear_sched();
        s_bff[11] = 1'b1; s_bff[12] = 1'b1; s_bff[13] = 1'b1;
        run(8'd5, 17);
        for (int c = 11; c <= 13; c++) begin
            checks++;
            if (r_bwe[c] !== 1'b0 || r_b[c] !== 16'sd0 || r_done[c] !== 1'b0) begin
                failures++; $display("FAIL bff_hold cycle=%0d got bwe=%b b=%0d done=%b want 0/0/0", c, r_bwe[c], r_b[c], r_done[c]);
            end
        end
        for (int c = 1; c <= 17; c++) begin
            if (r_bwe[c] && kb < 5) begin
                checks++;
                if (c !== ec[kb]) begin
                    failures++; $display("FAIL bff_b%0d got cyc=%0d want cyc=%0d", kb, c, ec[kb]);
                end
                kb++;
            end
        end
        checks++;
        if (first_done(17) !== 15 || count_sig(2, 17) !== 5) begin
            failures++; $display("FAIL bff_done got cyc=%0d bwe=%0d want 15/5", first_done(17), count_sig(2, 17));
        end
    endtask

    task automatic test_len_edges();
        int ka = 0, kb = 0;
        clear_sched();
        run(8'd0, 4);
        checks++;
        if (first_done(4) !== 1 || count_sig(0, 4) + count_sig(1, 4) + count_sig(2, 4) + count_sig(3, 4) !== 0) begin
            failures++; $display("FAIL len0 got done=%0d activity=%0d want 1/0", first_done(4),
                count_sig(0, 4) + count_sig(1, 4) + count_sig(2, 4) + count_sig(3, 4));
        end
        for (int i = 0; i < DEPTH; i++) load(i, i * 7 - 20, 1000 - i);
        run(8'd40, 38);
        for (int c = 1; c <= 38; c++) begin
            if (r_awe[c]) begin
                checks++;
                if (r_a[c] !== 16'(ka * 7 - 20)) begin
                    failures++; $display("FAIL len40_a%0d got %0d want %0d", ka, r_a[c], ka * 7 - 20);
                end
                ka++;
            end
            if (r_bwe[c]) begin
                checks++;
                if (r_b[c] !== 16'(1000 - kb)) begin
                    failures++; $display("FAIL len40_b%0d got %0d want %0d", kb, r_b[c], 1000 - kb);
                end
                kb++;
            end
        end
        checks++;
        if (ka !== 16 || kb !== 16 || first_done(38) !== 34) begin
            failures++; $display("FAIL len40_count got awe=%0d bwe=%0d done=%0d want 16/16/34", ka, kb, first_done(38));
        end
    endtask

    task automatic test_midrun_ignore();
        int ea[5] = '{100, 200, 255, 100, 0};
        int eb[5] = '{200, 130, 256, 300, 0};
        int ka = 0, kb = 0;
        load_orig();
        clear_sched();
        s_inj[5] = 1'b1;
        run(8'd5, 14);
        for (int c = 1; c <= 14; c++) begin
            if (r_awe[c] && ka < 5) begin
                checks++;
                if (r_a[c] !== 16'(ea[ka])) begin
                    failures++; $display("FAIL mid_a%0d got %0d want %0d", ka, r_a[c], ea[ka]);
                end
                ka++;
            end
            if (r_bwe[c] && kb < 5) begin
                checks++;
                if (r_b[c] !== 16'(eb[kb])) begin
                    failures++; $display("FAIL mid_b%0d got %0d want %0d", kb, r_b[c], eb[kb]);
                end
                kb++;
            end
        end
        checks++;
        if (first_done(14) !== 12 || count_sig(0, 14) !== 1 || ka !== 5) begin
            failures++; $display("FAIL mid_done got done=%0d starts=%0d awe=%0d want 12/1/5", first_done(14), count_sig(0, 14), ka);
        end
        clear_sched();
        run(8'd1, 5);
        checks++;
        if (r_awe[2] !== 1'b1 || r_a[2] !== 16'sd100 || r_bwe[3] !== 1'b1 || r_b[3] !== 16'sd200 || first_done(5) !== 4) begin
            failures++; $display("FAIL mid_entry0 got awe=%b a=%0d bwe=%b b=%0d done=%0d want 1/100/1/200/4",
                r_awe[2], r_a[2], r_bwe[3], r_b[3], first_done(5));
        end
    endtask

    task automatic test_reset_midrun();
        clear_sched();
        s_rst[4] = 1'b1;
        run(8'd5, 14);
        checks++;
        if (r_awe[4] !== 1'b1) begin
            failures++; $display("FAIL rstmid_third_strobe got awe=%b want 1", r_awe[4]);
        end
        checks++;
        if ({r_start[5], r_awe[5], r_bwe[5], r_busy[5], r_done[5]} !== 5'b0 || r_a[5] !== 16'sd0 || r_b[5] !== 16'sd0) begin
            failures++; $display("FAIL rstmid_outputs got ctrl=%b a=%0d b=%0d want 00000/0/0",
                {r_start[5], r_awe[5], r_bwe[5], r_busy[5], r_done[5]}, r_a[5], r_b[5]);
        end
        checks++;
        if (count_sig(4, 14) !== 0) begin
            failures++; $display("FAIL rstmid_no_done got %0d want 0", count_sig(4, 14));
        end
        clear_sched();
        run(8'd2, 8);
        checks++;
        if (r_start[1] !== 1'b1 || r_a[2] !== 16'sd100 || r_b[3] !== 16'sd200 || r_a[4] !== 16'sd200
            || r_b[5] !== 16'sd130 || r_awe[4] !== 1'b1 || r_bwe[5] !== 1'b1 || first_done(8) !== 6) begin
            failures++; $display("FAIL rstmid_restart got start=%b a=%0d,%0d b=%0d,%0d done=%0d want 1 100,200 200,130 6",
                r_start[1], r_a[2], r_a[4], r_b[3], r_b[5], first_done(8));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aff_stall();
        test_bff_last();
        test_len_edges();
        test_midrun_ignore();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
